// File: rtl/gsr_pur_reset_ctrl.sv
// Global set/reset and power-up reset controller: asynchronous assertion, synchronous
// release, minimum power-up hold, debounced user request and stretched user release.
module gsr_pur_reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int PUR_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STRETCH_CYCLES  = 8
) (
    input  logic       CLK,
    input  logic       GSR_N,
    input  logic       usr_rst_n,
    output logic       rst_n_o,
    output logic       pur_done_o,
    output logic [1:0] rst_cause_o
);

    localparam int MAX_AB = (PUR_CYCLES > DEBOUNCE_CYCLES) ? PUR_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAX_P  = (MAX_AB > STRETCH_CYCLES) ? MAX_AB : STRETCH_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] PUR_LAST = CNT_W'(PUR_CYCLES - 1);
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] CAUSE_PUR = 2'b01;
    localparam logic [1:0] CAUSE_USR = 2'b10;

    typedef enum logic [2:0] {
        S_RESET,
        S_PUR_WAIT,
        S_RUN,
        S_USR_HOLD,
        S_STRETCH
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_gsr_sync;
    logic [SYNC_STAGES-1:0] r_usr_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       r_deb;
    logic [CNT_W-1:0]       w_deb_nxt;
    logic                   r_rst_n;
    logic                   w_rst_n_nxt;
    logic                   r_pur_done;
    logic                   w_pur_done_nxt;
    logic [1:0]             r_cause;
    logic [1:0]             w_cause_nxt;
    logic                   w_gsr_sync;
    logic                   w_usr_sync;
    logic                   w_usr_req;

    // GSR chain clears to 0 so release is seen late; user chain presets to "not requested".
    always_ff @(posedge CLK or negedge GSR_N) begin
        if (!GSR_N) begin
            r_gsr_sync <= '0;
            r_usr_sync <= '1;
        end else begin
            r_gsr_sync <= {r_gsr_sync[SYNC_STAGES-2:0], 1'b1};
            r_usr_sync <= {r_usr_sync[SYNC_STAGES-2:0], usr_rst_n};
        end
    end

    assign w_gsr_sync = r_gsr_sync[SYNC_STAGES-1];
    assign w_usr_sync = r_usr_sync[SYNC_STAGES-1];

    always_comb begin
        w_deb_nxt = r_deb;
        if (r_state == S_RESET || w_usr_sync) begin
            w_deb_nxt = '0;
        end else if (r_deb != DEB_MAX) begin
            w_deb_nxt = r_deb + CNT_ONE;
        end
    end

    // Request is taken from the next count so the reset falls on the edge that saturates it.
    assign w_usr_req = (w_deb_nxt == DEB_MAX);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rst_n_nxt    = r_rst_n;
        w_pur_done_nxt = r_pur_done;
        w_cause_nxt    = r_cause;
        unique case (r_state)
            S_RESET: begin
                if (w_gsr_sync) begin
                    if (PUR_CYCLES == 1) begin
                        w_state_nxt    = S_RUN;
                        w_rst_n_nxt    = 1'b1;
                        w_pur_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_PUR_WAIT;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            S_PUR_WAIT: begin
                if (r_cnt >= PUR_LAST) begin
                    w_state_nxt    = S_RUN;
                    w_cnt_nxt      = '0;
                    w_rst_n_nxt    = 1'b1;
                    w_pur_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (w_usr_req) begin
                    w_state_nxt = S_USR_HOLD;
                    w_rst_n_nxt = 1'b0;
                    w_cause_nxt = CAUSE_USR;
                end
            end
            S_USR_HOLD: begin
                // The release edge itself is the first stretch cycle.
                if (w_usr_sync) begin
                    if (STRETCH_CYCLES == 1) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                        w_rst_n_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_STRETCH;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            S_STRETCH: begin
                if (!w_usr_sync) begin
                    w_state_nxt = S_USR_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= STR_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_rst_n_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_RESET;
                w_cnt_nxt   = '0;
                w_rst_n_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge GSR_N) begin
        if (!GSR_N) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_deb      <= '0;
            r_rst_n    <= 1'b0;
            r_pur_done <= 1'b0;
            r_cause    <= CAUSE_PUR;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_deb      <= w_deb_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_pur_done <= w_pur_done_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    assign rst_n_o     = r_rst_n;
    assign pur_done_o  = r_pur_done;
    assign rst_cause_o = r_cause;

endmodule

// File: tb/tb_gsr_pur_reset_ctrl.sv
// Scoreboarded bench for gsr_pur_reset_ctrl: expected rst_n_o transition edges are
// queued as stimulus is applied and checked when the output moves.
module tb_gsr_pur_reset_ctrl;

    localparam int SYNC     = 2;
    localparam int PUR      = 16;
    localparam int DEB      = 4;
    localparam int STR      = 8;
    localparam int PUR_LAT  = SYNC + PUR;
    localparam int USR_LAT  = SYNC + DEB;
    localparam int REL_LAT  = SYNC + STR;
    localparam int BUDGET   = 80;

    typedef struct {
        string name;
        logic  lvl;
        int    at;
    } exp_t;

    logic       CLK = 1'b0;
    logic       GSR_N;
    logic       usr_rst_n;
    logic       rst_n_o;
    logic       pur_done_o;
    logic [1:0] rst_cause_o;

    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    exp_t sb[$];

    gsr_pur_reset_ctrl #(
        .SYNC_STAGES    (SYNC),
        .PUR_CYCLES     (PUR),
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES (STR)
    ) dut (
        .CLK        (CLK),
        .GSR_N      (GSR_N),
        .usr_rst_n  (usr_rst_n),
        .rst_n_o    (rst_n_o),
        .pur_done_o (pur_done_o),
        .rst_cause_o(rst_cause_o)
    );

    always #10 CLK = ~CLK;
    always @(posedge CLK) edge_cnt++;

    task automatic expect_edge(input string nm, input logic lvl, input int at);
        exp_t e;
        e.name = nm;
        e.lvl  = lvl;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Returns the edge number on which rst_n_o reached lvl, or -1 if the budget ran out.
    task automatic wait_level(input logic lvl, input int budget, output int at_edge);
        at_edge = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            #1;
            if (rst_n_o === lvl) begin
                at_edge = edge_cnt;
                break;
            end
        end
    endtask

    task automatic goto_edge(input int tgt);
        do @(negedge CLK); while (edge_cnt < tgt);
    endtask

    task automatic test_reset();
        exp_t e;
        int   got;
        int   base;
        GSR_N     = 1'b0;
        usr_rst_n = 1'b1;
        repeat (10) @(negedge CLK);
        n_cmp++;
        if (rst_n_o !== 1'b0) begin
            n_err++; $display("FAIL reset_rst_n: got %b, want 0", rst_n_o);
        end
        n_cmp++;
        if (pur_done_o !== 1'b0) begin
            n_err++; $display("FAIL reset_pur_done: got %b, want 0", pur_done_o);
        end
        n_cmp++;
        if (rst_cause_o !== 2'b01) begin
            n_err++; $display("FAIL reset_cause: got %b, want 01", rst_cause_o);
        end
        base  = edge_cnt;
        GSR_N = 1'b1;
        expect_edge("pur_release", 1'b1, base + PUR_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        n_cmp++;
        if (pur_done_o !== 1'b1) begin
            n_err++; $display("FAIL pur_done_set: got %b, want 1", pur_done_o);
        end
        n_cmp++;
        if (rst_cause_o !== 2'b01) begin
            n_err++; $display("FAIL pur_cause: got %b, want 01", rst_cause_o);
        end
    endtask

    task automatic test_short_pulse();
        int low_cycles;
        repeat (5) @(negedge CLK);
        usr_rst_n = 1'b0;
        repeat (DEB - 1) @(negedge CLK);
        usr_rst_n = 1'b1;
        low_cycles = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (rst_n_o !== 1'b1) low_cycles++;
        end
        n_cmp++;
        if (low_cycles !== 0) begin
            n_err++; $display("FAIL short_pulse_rst_n: low for %0d cycles, want 0", low_cycles);
        end
        n_cmp++;
        if (rst_cause_o !== 2'b01) begin
            n_err++; $display("FAIL short_pulse_cause: got %b, want 01", rst_cause_o);
        end
    endtask

    task automatic test_debounce_boundary();
        exp_t e;
        int   got;
        int   base;
        repeat (5) @(negedge CLK);
        base      = edge_cnt;
        usr_rst_n = 1'b0;
        expect_edge("deb_min_fall", 1'b0, base + USR_LAT);
        expect_edge("deb_min_rise", 1'b1, base + DEB + REL_LAT);
        repeat (DEB) @(negedge CLK);
        usr_rst_n = 1'b1;
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        n_cmp++;
        if (rst_cause_o !== 2'b10) begin
            n_err++; $display("FAIL deb_min_cause: got %b, want 10", rst_cause_o);
        end
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
    endtask

    task automatic test_user_reset();
        exp_t e;
        int   got;
        int   base;
        int   rel;
        repeat (5) @(negedge CLK);
        base      = edge_cnt;
        usr_rst_n = 1'b0;
        expect_edge("usr_fall", 1'b0, base + USR_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        n_cmp++;
        if (rst_cause_o !== 2'b10) begin
            n_err++; $display("FAIL usr_cause: got %b, want 10", rst_cause_o);
        end
        goto_edge(base + 24);
        rel       = edge_cnt;
        usr_rst_n = 1'b1;
        expect_edge("usr_release", 1'b1, rel + REL_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        n_cmp++;
        if (pur_done_o !== 1'b1 || rst_cause_o !== 2'b10) begin
            n_err++; $display("FAIL usr_hold_flags: pur_done=%b cause=%b, want 1/10", pur_done_o, rst_cause_o);
        end
    endtask

    task automatic test_gsr_async_run();
        exp_t e;
        int   got;
        int   base;
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #3;
        GSR_N = 1'b0;
        #1;
        n_cmp++;
        if (rst_n_o !== 1'b0 || pur_done_o !== 1'b0) begin
            n_err++; $display("FAIL gsr_async_run: rst_n=%b pur_done=%b, want 0/0", rst_n_o, pur_done_o);
        end
        n_cmp++;
        if (rst_cause_o !== 2'b01) begin
            n_err++; $display("FAIL gsr_async_cause: got %b, want 01", rst_cause_o);
        end
        repeat (3) @(negedge CLK);
        base  = edge_cnt;
        GSR_N = 1'b1;
        expect_edge("gsr_run_pur", 1'b1, base + PUR_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
    endtask

    task automatic test_gsr_mid_stretch();
        exp_t e;
        int   got;
        int   base;
        int   rel;
        repeat (5) @(negedge CLK);
        base      = edge_cnt;
        usr_rst_n = 1'b0;
        expect_edge("stretch_gsr_fall", 1'b0, base + USR_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        goto_edge(base + 8);
        rel       = edge_cnt;
        usr_rst_n = 1'b1;
        goto_edge(rel + SYNC + 3);
        GSR_N = 1'b0;
        #1;
        n_cmp++;
        if (rst_n_o !== 1'b0 || pur_done_o !== 1'b0 || rst_cause_o !== 2'b01) begin
            n_err++; $display("FAIL gsr_mid_stretch: rst_n=%b pur_done=%b cause=%b, want 0/0/01",
                              rst_n_o, pur_done_o, rst_cause_o);
        end
        repeat (3) @(negedge CLK);
        base  = edge_cnt;
        GSR_N = 1'b1;
        expect_edge("stretch_gsr_pur", 1'b1, base + PUR_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        n_cmp++;
        if (pur_done_o !== 1'b1) begin
            n_err++; $display("FAIL stretch_gsr_pur_done: got %b, want 1", pur_done_o);
        end
    endtask

    task automatic test_usr_across_gsr();
        exp_t e;
        int   got;
        int   base;
        int   rel;
        @(negedge CLK);
        GSR_N     = 1'b0;
        usr_rst_n = 1'b0;
        repeat (4) @(negedge CLK);
        base  = edge_cnt;
        GSR_N = 1'b1;
        expect_edge("across_pur_rise", 1'b1, base + PUR_LAT);
        expect_edge("across_usr_fall", 1'b0, base + PUR_LAT + 1);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        n_cmp++;
        if (rst_cause_o !== 2'b10 || pur_done_o !== 1'b1) begin
            n_err++; $display("FAIL across_flags: cause=%b pur_done=%b, want 10/1", rst_cause_o, pur_done_o);
        end
        goto_edge(base + 30);
        rel       = edge_cnt;
        usr_rst_n = 1'b1;
        expect_edge("across_release", 1'b1, rel + REL_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
    endtask

    task automatic test_restretch();
        exp_t e;
        int   got;
        int   base;
        int   rel;
        int   rel2;
        repeat (5) @(negedge CLK);
        base      = edge_cnt;
        usr_rst_n = 1'b0;
        expect_edge("restretch_fall", 1'b0, base + USR_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
        goto_edge(base + 10);
        rel       = edge_cnt;
        usr_rst_n = 1'b1;
        goto_edge(rel + SYNC + 2);
        usr_rst_n = 1'b0;
        repeat (5) @(negedge CLK);
        rel2 = edge_cnt;
        n_cmp++;
        if (rst_n_o !== 1'b0) begin
            n_err++; $display("FAIL restretch_hold: got %b, want 0", rst_n_o);
        end
        usr_rst_n = 1'b1;
        expect_edge("restretch_release", 1'b1, rel2 + REL_LAT);
        e = sb.pop_front();
        wait_level(e.lvl, BUDGET, got);
        n_cmp++;
        if (got !== e.at) begin
            n_err++; $display("FAIL %s: rst_n_o=%b at edge %0d, want edge %0d", e.name, e.lvl, got, e.at);
        end
    endtask

    initial begin
        test_reset();
        test_short_pulse();
        test_debounce_boundary();
        test_user_reset();
        test_gsr_async_run();
        test_gsr_mid_stretch();
        test_usr_across_gsr();
        test_restretch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

endmodule
